polylut_stream_feeder: RTL and testbench
========================================

Name: polylut_stream_feeder

Overview:
Stream-side front/back end for the pipelined PolyLUT network top. It deserialises a narrow feature stream (valid/ready) into the packed input vector that drives the network's M0 port. It tracks each launched vector through the fixed-latency, non-stallable network pipeline and captures the matching M10 result into a result FIFO with valid/ready. Credit-based launch control ensures a result is never dropped when the downstream consumer stalls.

Parameters:
FEAT_W, 7, bits per input feature
NUM_FEAT, 16, features per vector (vector width NUM_FEAT*FEAT_W = 112)
CLS_W, 5, bits per class score
NUM_CLS, 5, class scores per result (result width NUM_CLS*CLS_W = 25)
PIPE_LAT, 10, register stages in the network from M0 to M10
RES_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  feature word valid
s_ready  out  1  feature word accepted when s_valid&&s_ready
s_data  in  FEAT_W  feature word; the first word of a vector is feature 0
net_vec  out  NUM_FEAT*FEAT_W  registered vector; drives network M0
net_res  in  NUM_CLS*CLS_W  network M10 output
r_valid  out  1  result available
r_ready  in  1  consumer accepts result
r_data  out  NUM_CLS*CLS_W  head-of-FIFO result

Behaviour:
- Reset: synchronous active-high on clk. On reset, all state is cleared:
  - Outputs: s_ready=0 for the reset cycle, then 1. net_vec=0, r_valid=0, r_data=0.
  - Internals: feature index, shadow vector, token line, FIFO pointers and count, and in-flight count are all cleared.
  - Reset mid-operation discards any partial vector, in-flight tokens and FIFO contents. The network shares the same rst.
- Packing: feature i is written to the shadow vector at bits [i*FEAT_W +: FEAT_W].
- FSM states:
  - COLLECT: s_ready=1. Each handshake stores the word and increments the index. Accepting word NUM_FEAT-1 resets the index to 0 and moves to FULL.
  - FULL: s_ready=0. Launch when in_flight + fifo_count < RES_DEPTH. On launch, net_vec <= shadow, a token is pushed into the delay line, and the FSM returns to COLLECT on the same edge. Without credit, the FSM stays in FULL and net_vec holds its value.
- Throughput: at best one vector per NUM_FEAT+1 cycles.
- Latency: for a launch at edge E, net_res is sampled in the cycle between edges E+PIPE_LAT and E+PIPE_LAT+1, and written into the FIFO at edge E+PIPE_LAT+1.
  - net_res in cycles with no matching token is ignored; the network runs freely.
- Token delay line: a PIPE_LAT+1 bit shift register, shifted every cycle.
  - in_flight counts the tokens in the line.
  - in_flight increments on launch and decrements on FIFO write; both in the same cycle leave it unchanged.
- Result FIFO:
  - r_valid = (count != 0); r_data shows the head entry.
  - Pop on r_valid&&r_ready. Simultaneous push and pop keeps count unchanged and must not corrupt the head.
  - Pointers wrap modulo RES_DEPTH.
  - The credit rule guarantees that a push never occurs while full. A push into a full FIFO is a design error (assertion).
- When the FIFO is full and r_ready=0: the FSM stalls in FULL, s_ready=0, and upstream backpressure is applied after at most NUM_FEAT further words.

Optional Feature:
POLYLUT_FEED_ARGMAX_EN
- Defined:
  - Adds output port r_class [$clog2(NUM_CLS)-1:0].
  - r_class is the index of the maximum class score in each captured result. Scores are signed two's complement CLS_W bits; ties resolve to the lowest index.
  - It is computed at FIFO write, stored alongside the entry and presented with r_data. It resets to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then stream words 1..16 back-to-back with r_ready=1.
   -> Shadow-to-net_vec load at the edge after word 16, so net_vec[6:0]=1 and net_vec[111:105]=16.
   -> r_valid rises PIPE_LAT+1 edges later, with r_data equal to the stubbed net_res for that vector.
2. r_ready=0 and 6 vectors streamed.
   -> 4 launches, FIFO count=4, s_ready=0 after the 5th vector's 16 words, no 5th launch.
   -> Then r_ready=1: results pop in order, launch resumes, all 6 results delivered with none lost or duplicated.
3. Hold r_ready=1 with a launch in flight, and inject net_res garbage in non-token cycles.
   -> Only token-aligned values appear on r_data.
4. Assert rst after 9 words of a vector and with 2 results in flight.
   -> The next cycle has r_valid=0 and net_vec=0. The next 16 words form a fresh vector with feature 0 taken from the first post-reset word, and no stale results appear.
5. Push and pop in the same cycle with count=1 and r_ready=1 at continuous launch.
   -> count stays 1, r_data advances correctly, and pointers wrap past RES_DEPTH-1 to 0.
6. With POLYLUT_FEED_ARGMAX_EN defined, inject scores {-3,7,7,0,-16} (class 0 to class 4).
   -> r_class=1 (tie resolved low). With scores all -16, r_class=0.

Source files
------------

// File: rtl/polylut_stream_feeder.sv
// polylut_stream_feeder: feature-stream deserialiser, in-flight tracker and
// result FIFO around the fixed-latency PolyLUT network.
// Optional: POLYLUT_FEED_ARGMAX_EN adds r_class (argmax of each result).
module polylut_stream_feeder #(
    parameter int FEAT_W    = 7,
    parameter int NUM_FEAT  = 16,
    parameter int CLS_W     = 5,
    parameter int NUM_CLS   = 5,
    parameter int PIPE_LAT  = 10,
    parameter int RES_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [FEAT_W-1:0]            s_data,
    output logic [NUM_FEAT*FEAT_W-1:0]   net_vec,
    input  logic [NUM_CLS*CLS_W-1:0]     net_res,
    output logic                         r_valid,
    input  logic                         r_ready,
`ifdef POLYLUT_FEED_ARGMAX_EN
    output logic [$clog2(NUM_CLS)-1:0]   r_class,
`endif
    output logic [NUM_CLS*CLS_W-1:0]     r_data
);

    localparam int VW  = NUM_FEAT * FEAT_W;
    localparam int RW  = NUM_CLS * CLS_W;
    localparam int IW  = $clog2(NUM_FEAT);
    localparam int PW  = $clog2(RES_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(RES_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t             state_q;
    logic               s_ready_q;
    logic [IW-1:0]      idx_q;
    logic [VW-1:0]      shadow_q;
    logic [VW-1:0]      net_vec_q;
    logic [PIPE_LAT:0]  tok_q;
    logic [CW-1:0]      inflt_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      wp_q;
    logic [PW-1:0]      rp_q;
    logic [RW-1:0]      mem_q [RES_DEPTH];

    logic accept;
    logic credit;
    logic launch;
    logic push;
    logic pop;

    assign accept  = s_valid && s_ready_q;
    // Launch only when every outstanding result already has a FIFO slot.
    assign credit  = ({1'b0, inflt_q} + {1'b0, cnt_q}) < DEPTH_S;
    assign launch  = (state_q == FULL) && credit;
    assign push    = tok_q[PIPE_LAT];
    assign r_valid = (cnt_q != '0);
    assign pop     = r_valid && r_ready;

    assign s_ready = s_ready_q;
    assign net_vec = net_vec_q;
    assign r_data  = mem_q[rp_q];

    // Collect/launch FSM: pack features into the shadow, then hand off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            s_ready_q <= 1'b0;
            idx_q     <= '0;
            shadow_q  <= '0;
            net_vec_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        shadow_q[int'(idx_q)*FEAT_W +: FEAT_W] <= s_data;
                        if (idx_q == IW'(NUM_FEAT-1)) begin
                            idx_q     <= '0;
                            state_q   <= FULL;
                            s_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (launch) begin
                        net_vec_q <= shadow_q;
                        state_q   <= COLLECT;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= COLLECT;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Token line mirrors the network pipeline; in_flight counts its tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_q   <= '0;
            inflt_q <= '0;
        end else begin
            tok_q <= {tok_q[PIPE_LAT-1:0], launch};
            case ({launch, push})
                2'b10:   inflt_q <= inflt_q + 1'b1;
                2'b01:   inflt_q <= inflt_q - 1'b1;
                default: inflt_q <= inflt_q;
            endcase
        end
    end

`ifdef POLYLUT_FEED_ARGMAX_EN
    localparam int CIW = $clog2(NUM_CLS);

    logic [CIW-1:0]          amax;
    logic signed [CLS_W-1:0] best;
    logic signed [CLS_W-1:0] cur;
    logic [CIW-1:0]          cls_q [RES_DEPTH];

    // Signed argmax; strict compare keeps the lowest index on ties.
    always_comb begin
        amax = '0;
        best = $signed(net_res[CLS_W-1:0]);
        cur  = '0;
        for (int i = 1; i < NUM_CLS; i++) begin
            cur = $signed(net_res[i*CLS_W +: CLS_W]);
            if (cur > best) begin
                best = cur;
                amax = CIW'(i);
            end
        end
    end

    assign r_class = cls_q[rp_q];

    // Class index stored next to its result entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RES_DEPTH; i++) cls_q[i] <= '0;
        end else if (push) begin
            cls_q[wp_q] <= amax;
        end
    end
`endif

    // Result FIFO: push on token exit, pop on consumer handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q] <= net_res;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Credit control must make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (cnt_q != DEPTH_C)
            else $error("result FIFO overflow");
        end
    end

endmodule

// File: tb/tb_polylut_stream_feeder.sv
// Bench for polylut_stream_feeder: stub network with free-running output,
// scoreboard of expected results, directed steps in one initial block.
module tb_polylut_stream_feeder;

    localparam int FEAT_W    = 7;
    localparam int NUM_FEAT  = 16;
    localparam int CLS_W     = 5;
    localparam int NUM_CLS   = 5;
    localparam int PIPE_LAT  = 10;
    localparam int RES_DEPTH = 4;
    localparam int VW        = NUM_FEAT * FEAT_W;
    localparam int RW        = NUM_CLS * CLS_W;
    localparam int LIM       = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [6:0]    s_data;
    logic [VW-1:0] net_vec;
    logic [RW-1:0] net_res;
    logic          r_valid;
    logic          r_ready;
    logic [RW-1:0] r_data;
`ifdef POLYLUT_FEED_ARGMAX_EN
    logic [2:0]    r_class;
`endif

    always #5 clk = ~clk;

    polylut_stream_feeder #(
        .FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT), .CLS_W(CLS_W),
        .NUM_CLS(NUM_CLS), .PIPE_LAT(PIPE_LAT), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .net_vec(net_vec), .net_res(net_res),
        .r_valid(r_valid), .r_ready(r_ready),
`ifdef POLYLUT_FEED_ARGMAX_EN
        .r_class(r_class),
`endif
        .r_data(r_data)
    );

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int words_acc = 0;

    logic [RW-1:0] exp_q [$];
    int            cls_q [$];
    logic [VW-1:0] vec_log [$];
    logic [VW-1:0] last_vec;
    logic [RW-1:0] last_exp;
    logic [6:0]    nb;

    logic          garbage_en;
    logic          force_en;
    logic [RW-1:0] force_val;

    function automatic logic [RW-1:0] net_f(input logic [VW-1:0] v);
        return v[24:0] ^ v[49:25] ^ v[74:50] ^ v[99:75] ^ {13'd0, v[111:100]};
    endfunction

    function automatic int argmax_ref(input logic [RW-1:0] r);
        int b = 0;
        for (int i = 1; i < NUM_CLS; i++) begin
            if ($signed(r[i*CLS_W +: CLS_W]) > $signed(r[b*CLS_W +: CLS_W])) b = i;
        end
        return b;
    endfunction

    // Stub network: PIPE_LAT stages, garbage whenever no new vector is aligned.
    logic [RW-1:0]       pipe_q [PIPE_LAT];
    logic [PIPE_LAT-1:0] vld_q;
    logic [VW-1:0]       prev_q;
    logic [RW-1:0]       junk;

    always @(posedge clk) begin
        junk <= RW'($urandom);
        if (rst) begin
            vld_q  <= '0;
            prev_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
        end else begin
            prev_q    <= net_vec;
            vld_q     <= {vld_q[PIPE_LAT-2:0], net_vec != prev_q};
            pipe_q[0] <= force_en ? force_val : net_f(net_vec);
            for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign net_res = (garbage_en && !vld_q[PIPE_LAT-1]) ? junk : pipe_q[PIPE_LAT-1];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every consumer handshake pops and compares one entry.
    always @(negedge clk) begin
        if (!rst && r_valid && r_ready) begin
            pops++;
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_result observed=%0h expected=none", r_data);
            end
            if (exp_q.size() != 0) begin
                chk("r_data", r_data, exp_q.pop_front());
`ifdef POLYLUT_FEED_ARGMAX_EN
                chk("r_class", r_class, cls_q.pop_front());
`else
                void'(cls_q.pop_front());
`endif
            end
        end
    end

    task automatic send_word(input logic [6:0] d);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            checks++;
            errors++;
            $error("FAIL s_ready_timeout observed=0 expected=1");
        end else begin
            @(posedge clk);
            words_acc++;
        end
        #1 s_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [6:0] base);
        logic [VW-1:0] v;
        logic [RW-1:0] e;
        logic [6:0]    w;
        v = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            w = base + 7'(i);
            v[i*FEAT_W +: FEAT_W] = w;
        end
        e = force_en ? force_val : net_f(v);
        exp_q.push_back(e);
        cls_q.push_back(argmax_ref(e));
        vec_log.push_back(v);
        last_vec = v;
        last_exp = e;
        for (int i = 0; i < NUM_FEAT; i++) begin
            w = base + 7'(i);
            send_word(w);
        end
    endtask

    task automatic send_next();
        send_vec(nb);
        nb = nb + 7'd19;
    endtask

    task automatic wait_drain();
        int n = 0;
        r_ready = 1'b1;
        while ((exp_q.size() != 0 || r_valid) && n < LIM) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_in_time", n < LIM, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!r_valid && n < LIM) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("valid_in_time", n < LIM, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int w0;
        int vb;
        int n;
        logic sender_done;

        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        r_ready    = 1'b1;
        garbage_en = 1'b1;
        force_en   = 1'b0;
        force_val  = '0;
        nb         = 7'd1;
        sender_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_net_vec", net_vec, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
`ifdef POLYLUT_FEED_ARGMAX_EN
        chk("rst_r_class", r_class, 0);
`endif
        rst = 1'b0;

        // Step 1: words 1..16, load then fixed latency
        send_next();
        @(posedge clk);
        #1;
        chk("vec_feat0", net_vec[6:0], 1);
        chk("vec_feat15", net_vec[111:105], 16);
        repeat (PIPE_LAT) @(posedge clk);
        #1;
        chk("lat_not_yet", r_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", r_valid, 1);
        chk("lat_data", r_data, last_exp);
        wait_drain();

        // Step 2: consumer stalled, six vectors offered
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        p0 = pops;
        w0 = words_acc;
        vb = vec_log.size();
        fork
            begin
                for (int k = 0; k < 6; k++) send_next();
                sender_done = 1'b1;
            end
        join_none
        repeat (150) @(posedge clk);
        #1;
        chk("stall_s_ready", s_ready, 0);
        chk("stall_r_valid", r_valid, 1);
        chk("stall_words", words_acc - w0, 5 * NUM_FEAT);
        chk("stall_no_5th", net_vec, vec_log[vb+3]);
        chk("stall_head", r_data, net_f(vec_log[vb]));
        r_ready = 1'b1;
        n = 0;
        while (!sender_done && n < LIM) begin
            @(posedge clk);
            n++;
        end
        chk("sender_done", sender_done, 1);
        wait_drain();
        chk("stall_all_out", pops - p0, 6);

        // Step 3: single vector among garbage cycles
        p0 = pops;
        send_next();
        wait_drain();
        repeat (20) @(posedge clk);
        #1;
        chk("garbage_pops", pops - p0, 1);
        chk("garbage_idle", r_valid, 0);

        // Step 4: reset mid-vector with results pending
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        send_next();
        send_next();
        for (int i = 0; i < 9; i++) send_word(nb + 7'(i));
        rst = 1'b1;
        exp_q.delete();
        cls_q.delete();
        @(posedge clk);
        #1;
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_net_vec", net_vec, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        rst = 1'b0;
        r_ready = 1'b1;
        p0 = pops;
        nb = 7'd100;
        send_next();
        @(posedge clk);
        #1;
        chk("post_rst_feat0", net_vec[6:0], 100);
        chk("post_rst_vec", net_vec, last_vec);
        wait_drain();
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_pops", pops - p0, 1);
        chk("post_rst_idle", r_valid, 0);

        // Step 5: simultaneous push/pop at count 1, pointer wrap
        r_ready = 1'b0;
        send_next();
        repeat (PIPE_LAT + 2) @(posedge clk);
        #1;
        chk("one_held", r_valid, 1);
        for (int k = 0; k < 5; k++) begin
            send_next();
            repeat (PIPE_LAT + 1) @(posedge clk);
            #1 r_ready = 1'b1;
            @(posedge clk);
            #1 r_ready = 1'b0;
            chk("pp_valid", r_valid, 1);
            chk("pp_head", r_data, last_exp);
        end
        wait_drain();

`ifdef POLYLUT_FEED_ARGMAX_EN
        // Step 6: argmax tie and all-equal cases
        force_en  = 1'b1;
        force_val = {5'b10000, 5'b00000, 5'b00111, 5'b00111, 5'b11101};
        r_ready   = 1'b0;
        send_next();
        wait_valid();
        chk("argmax_tie", r_class, 1);
        chk("argmax_tie_data", r_data, force_val);
        wait_drain();
        r_ready   = 1'b0;
        force_val = {5{5'b10000}};
        send_next();
        wait_valid();
        chk("argmax_equal", r_class, 0);
        wait_drain();
        force_en = 1'b0;
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
